router_axis_gearbox: RTL and testbench

//  Width-adapting AXI-Stream <-> flit bridge between a local node and the packetizer/depacketizer pair.

---
 rtl/router_axis_gearbox_pkg.sv | 21 ++
 rtl/router_axis_gearbox_deser.sv | 103 ++++++++++
 rtl/router_axis_gearbox.sv | 136 +++++++++++++
 tb/tb_router_axis_gearbox.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_axis_gearbox_pkg.sv
// Shared sizing helpers for the AXIS <-> flit gearbox: segment-index width and
// the last-beat tkeep to flit-count mapping.
package router_axis_gearbox_pkg;

    localparam int MAX_RATIO = 64;

    function automatic int seg_w(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

    // Flit count of a last beat: index of the first cleared keep bit, at least 1.
    function automatic int keep_to_nseg(input logic [MAX_RATIO-1:0] keep, input int ratio);
        int n;
        n = ratio;
        for (int i = MAX_RATIO - 1; i >= 0; i--) begin
            if (i < ratio && !keep[i]) n = i;
        end
        return (n == 0) ? 1 : n;
    endfunction

endpackage

// File: rtl/router_axis_gearbox_deser.sv
// RX side: gathers RATIO flits into one AXIS beat, with a single output register
// and a sticky flag for packets whose source address changes mid-packet.
module router_axis_gearbox_deser
    import router_axis_gearbox_pkg::*;
#(
    parameter int FLIT_DATA_WIDTH   = 64,
    parameter int RATIO             = 4,
    parameter int ROUTER_ADDR_WIDTH = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               rx_flit_valid,
    output logic                               rx_flit_ready,
    input  logic [FLIT_DATA_WIDTH-1:0]         rx_flit_data,
    input  logic                               rx_flit_last,
    input  logic [ROUTER_ADDR_WIDTH-1:0]       rx_flit_src,
    output logic                               m_axis_tvalid,
    input  logic                               m_axis_tready,
    output logic [RATIO*FLIT_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [RATIO-1:0]                   m_axis_tkeep,
    output logic                               m_axis_tlast,
    output logic [ROUTER_ADDR_WIDTH-1:0]       m_axis_tid,
    output logic                               rx_src_error
);
    localparam int FW    = FLIT_DATA_WIDTH;
    localparam int SEG_W = seg_w(RATIO);

    logic [RATIO*FW-1:0]          r_acc;
    logic [SEG_W-1:0]             r_rseg;
    logic                         r_in_pkt;
    logic [ROUTER_ADDR_WIDTH-1:0] r_pkt_src;
    logic                         r_out_v;
    logic [RATIO*FW-1:0]          r_out_data;
    logic [RATIO-1:0]             r_out_keep;
    logic                         r_out_last;
    logic [ROUTER_ADDR_WIDTH-1:0] r_out_tid;
    logic                         r_err;

    logic                w_complete;
    logic                w_acc;
    logic [RATIO*FW-1:0] w_beat;
    logic [RATIO-1:0]    w_keep;

    assign w_complete    = (r_rseg == SEG_W'(RATIO - 1)) | rx_flit_last;
    assign rx_flit_ready = !w_complete | !r_out_v | m_axis_tready;
    assign w_acc         = rx_flit_valid & rx_flit_ready;

    // Slots past the completing flit are zeroed so stale accumulator data never leaks.
    always_comb begin
        w_beat = '0;
        w_keep = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (k < int'(r_rseg)) begin
                w_beat[k*FW +: FW] = r_acc[k*FW +: FW];
                w_keep[k]          = 1'b1;
            end else if (k == int'(r_rseg)) begin
                w_beat[k*FW +: FW] = rx_flit_data;
                w_keep[k]          = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc      <= '0;
            r_rseg     <= '0;
            r_in_pkt   <= 1'b0;
            r_pkt_src  <= '0;
            r_out_v    <= 1'b0;
            r_out_data <= '0;
            r_out_keep <= '0;
            r_out_last <= 1'b0;
            r_out_tid  <= '0;
            r_err      <= 1'b0;
        end else begin
            if (m_axis_tready) r_out_v <= 1'b0;
            if (w_acc) begin
                if (!r_in_pkt) r_pkt_src <= rx_flit_src;
                else if (rx_flit_src != r_pkt_src) r_err <= 1'b1;
                r_in_pkt <= !rx_flit_last;
                if (w_complete) begin
                    r_out_v    <= 1'b1;
                    r_out_data <= w_beat;
                    r_out_keep <= w_keep;
                    r_out_last <= rx_flit_last;
                    r_out_tid  <= r_in_pkt ? r_pkt_src : rx_flit_src;
                    r_rseg     <= '0;
                end else begin
                    r_acc[r_rseg*FW +: FW] <= rx_flit_data;
                    r_rseg                 <= r_rseg + 1'b1;
                end
            end
        end
    end

    assign m_axis_tvalid = r_out_v;
    assign m_axis_tdata  = r_out_data;
    assign m_axis_tkeep  = r_out_keep;
    assign m_axis_tlast  = r_out_last;
    assign m_axis_tid    = r_out_tid;
    assign rx_src_error  = r_err;

endmodule

// File: rtl/router_axis_gearbox.sv
// AXI-Stream <-> flit gearbox: serializes each TX beat into RATIO flits (trimmed by
// tkeep on the last beat) and reassembles RX flits into beats, with packet counters.
module router_axis_gearbox
    import router_axis_gearbox_pkg::*;
#(
    parameter int FLIT_DATA_WIDTH   = 64,
    parameter int RATIO             = 4,
    parameter int ROUTER_ADDR_WIDTH = 4,
    parameter int LOCAL_ADDR        = 0,
    parameter int CNT_WIDTH         = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               s_axis_tvalid,
    output logic                               s_axis_tready,
    input  logic [RATIO*FLIT_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [RATIO-1:0]                   s_axis_tkeep,
    input  logic                               s_axis_tlast,
    input  logic [ROUTER_ADDR_WIDTH-1:0]       s_axis_tdest,
    input  logic [ROUTER_ADDR_WIDTH-1:0]       s_axis_tid,
    output logic                               tx_flit_valid,
    input  logic                               tx_flit_ready,
    output logic [FLIT_DATA_WIDTH-1:0]         tx_flit_data,
    output logic                               tx_flit_last,
    output logic [ROUTER_ADDR_WIDTH-1:0]       tx_flit_dest,
    output logic [ROUTER_ADDR_WIDTH-1:0]       tx_flit_src,
    input  logic                               rx_flit_valid,
    output logic                               rx_flit_ready,
    input  logic [FLIT_DATA_WIDTH-1:0]         rx_flit_data,
    input  logic                               rx_flit_last,
    input  logic [ROUTER_ADDR_WIDTH-1:0]       rx_flit_src,
    output logic                               m_axis_tvalid,
    input  logic                               m_axis_tready,
    output logic [RATIO*FLIT_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [RATIO-1:0]                   m_axis_tkeep,
    output logic                               m_axis_tlast,
    output logic [ROUTER_ADDR_WIDTH-1:0]       m_axis_tdest,
    output logic [ROUTER_ADDR_WIDTH-1:0]       m_axis_tid,
    output logic [CNT_WIDTH-1:0]               tx_pkt_count,
    output logic [CNT_WIDTH-1:0]               rx_pkt_count,
    output logic                               rx_src_error
);
    localparam int FW    = FLIT_DATA_WIDTH;
    localparam int SEG_W = seg_w(RATIO);
    localparam logic [SEG_W:0] NSEG_FULL = (SEG_W+1)'(RATIO);

    logic                         r_hold_v;
    logic [RATIO*FW-1:0]          r_hold_data;
    logic                         r_hold_last;
    logic [SEG_W:0]               r_hold_nseg;
    logic [SEG_W-1:0]             r_seg;
    logic [ROUTER_ADDR_WIDTH-1:0] r_dest;
    logic [ROUTER_ADDR_WIDTH-1:0] r_src;
    logic [CNT_WIDTH-1:0]         r_tx_cnt;
    logic [CNT_WIDTH-1:0]         r_rx_cnt;

    logic           w_last_seg;
    logic           w_load;
    logic [SEG_W:0] w_nseg;

    assign w_last_seg    = ({1'b0, r_seg} == r_hold_nseg - 1'b1);
    // Reload on the final segment's handshake keeps beats back-to-back.
    assign s_axis_tready = !r_hold_v | (tx_flit_ready & w_last_seg);
    assign w_load        = s_axis_tvalid & s_axis_tready;
    assign w_nseg        = s_axis_tlast
                         ? (SEG_W+1)'(keep_to_nseg(MAX_RATIO'(s_axis_tkeep), RATIO))
                         : NSEG_FULL;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold_v    <= 1'b0;
            r_hold_data <= '0;
            r_hold_last <= 1'b0;
            r_hold_nseg <= '0;
            r_seg       <= '0;
            r_dest      <= '0;
            r_src       <= '0;
            r_tx_cnt    <= '0;
        end else begin
            if (w_load) begin
                r_hold_v    <= 1'b1;
                r_hold_data <= s_axis_tdata;
                r_hold_last <= s_axis_tlast;
                r_hold_nseg <= w_nseg;
                r_seg       <= '0;
                r_dest      <= s_axis_tdest;
                r_src       <= s_axis_tid;
                if (s_axis_tlast) r_tx_cnt <= r_tx_cnt + 1'b1;
            end else if (r_hold_v & tx_flit_ready) begin
                if (w_last_seg) begin
                    r_hold_v <= 1'b0;
                    r_seg    <= '0;
                end else begin
                    r_seg <= r_seg + 1'b1;
                end
            end
        end
    end

    assign tx_flit_valid = r_hold_v;
    assign tx_flit_data  = r_hold_data[r_seg*FW +: FW];
    assign tx_flit_last  = r_hold_last & w_last_seg;
    assign tx_flit_dest  = r_dest;
    assign tx_flit_src   = r_src;
    assign tx_pkt_count  = r_tx_cnt;

    router_axis_gearbox_deser #(
        .FLIT_DATA_WIDTH  (FLIT_DATA_WIDTH),
        .RATIO            (RATIO),
        .ROUTER_ADDR_WIDTH(ROUTER_ADDR_WIDTH)
    ) u_deser (
        .clk          (clk),
        .reset        (reset),
        .rx_flit_valid(rx_flit_valid),
        .rx_flit_ready(rx_flit_ready),
        .rx_flit_data (rx_flit_data),
        .rx_flit_last (rx_flit_last),
        .rx_flit_src  (rx_flit_src),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tkeep (m_axis_tkeep),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tid   (m_axis_tid),
        .rx_src_error (rx_src_error)
    );

    always_ff @(posedge clk) begin
        if (reset) r_rx_cnt <= '0;
        else if (m_axis_tvalid & m_axis_tready & m_axis_tlast) r_rx_cnt <= r_rx_cnt + 1'b1;
    end

    assign m_axis_tdest = ROUTER_ADDR_WIDTH'(LOCAL_ADDR);
    assign rx_pkt_count = r_rx_cnt;

endmodule

// File: tb/tb_router_axis_gearbox.sv
// Bench for router_axis_gearbox (RATIO=4, 32-bit flits) against a queue-based reference model.
module tb_router_axis_gearbox;
    localparam int FW = 32, R = 4, AW = 4, LA = 2, CW = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic              s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic [R*FW-1:0]   s_axis_tdata;
    logic [R-1:0]      s_axis_tkeep;
    logic [AW-1:0]     s_axis_tdest, s_axis_tid;
    logic              tx_flit_valid, tx_flit_ready, tx_flit_last;
    logic [FW-1:0]     tx_flit_data;
    logic [AW-1:0]     tx_flit_dest, tx_flit_src;
    logic              rx_flit_valid, rx_flit_ready, rx_flit_last;
    logic [FW-1:0]     rx_flit_data;
    logic [AW-1:0]     rx_flit_src;
    logic              m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [R*FW-1:0]   m_axis_tdata;
    logic [R-1:0]      m_axis_tkeep;
    logic [AW-1:0]     m_axis_tdest, m_axis_tid;
    logic [CW-1:0]     tx_pkt_count, rx_pkt_count;
    logic              rx_src_error;

    router_axis_gearbox #(
        .FLIT_DATA_WIDTH(FW), .RATIO(R), .ROUTER_ADDR_WIDTH(AW), .LOCAL_ADDR(LA), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
        .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast), .s_axis_tdest(s_axis_tdest),
        .s_axis_tid(s_axis_tid),
        .tx_flit_valid(tx_flit_valid), .tx_flit_ready(tx_flit_ready), .tx_flit_data(tx_flit_data),
        .tx_flit_last(tx_flit_last), .tx_flit_dest(tx_flit_dest), .tx_flit_src(tx_flit_src),
        .rx_flit_valid(rx_flit_valid), .rx_flit_ready(rx_flit_ready), .rx_flit_data(rx_flit_data),
        .rx_flit_last(rx_flit_last), .rx_flit_src(rx_flit_src),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
        .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast), .m_axis_tdest(m_axis_tdest),
        .m_axis_tid(m_axis_tid),
        .tx_pkt_count(tx_pkt_count), .rx_pkt_count(rx_pkt_count), .rx_src_error(rx_src_error)
    );

    typedef struct { logic [R*FW-1:0] data; logic [R-1:0] keep; logic last; logic [AW-1:0] dest, src; } beat_t;
    typedef struct { logic [FW-1:0] data; logic last; logic [AW-1:0] dest, src; } flit_t;
    typedef struct { logic [FW-1:0] data; logic last; logic [AW-1:0] src; } rflit_t;
    typedef struct { logic [R*FW-1:0] data; logic [R-1:0] keep; logic last; logic [AW-1:0] tid; } rbeat_t;

    beat_t  tx_in[$];
    flit_t  tx_exp[$], tx_got[$];
    rflit_t rx_in[$];
    rbeat_t rx_exp[$], rx_got[$];
    int n_cmp = 0, n_bad = 0;
    int exp_tx_cnt = 0, exp_rx_cnt = 0;
    int tx_gaps, tx_nrdy, tx_unstable;
    bit tx_timeout, rx_timeout;

    function automatic logic [R*FW-1:0] rnd_beat();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Each beat yields 4 flits, except a last beat which yields (first cleared keep bit), min 1.
    function automatic void model_tx();
        tx_exp.delete();
        foreach (tx_in[b]) begin
            int n;
            n = R;
            if (tx_in[b].last) begin
                for (int i = R - 1; i >= 0; i--) if (!tx_in[b].keep[i]) n = i;
                if (n == 0) n = 1;
            end
            for (int k = 0; k < n; k++) begin
                flit_t f;
                f.data = tx_in[b].data[k*FW +: FW];
                f.last = tx_in[b].last && (k == n - 1);
                f.dest = tx_in[b].dest;
                f.src  = tx_in[b].src;
                tx_exp.push_back(f);
            end
        end
    endfunction

    // Pack flits 4 at a time, closing a beat early on the packet's last flit.
    function automatic void model_rx();
        logic [R*FW-1:0] acc;
        logic [R-1:0]    kp;
        logic [AW-1:0]   psrc;
        int s;
        bit first;
        rx_exp.delete();
        acc = '0; kp = '0; s = 0; first = 1; psrc = '0;
        foreach (rx_in[i]) begin
            if (first) psrc = rx_in[i].src;
            first = rx_in[i].last;
            acc[s*FW +: FW] = rx_in[i].data;
            kp[s] = 1'b1;
            s++;
            if (s == R || rx_in[i].last) begin
                rbeat_t rb;
                rb.data = acc; rb.keep = kp; rb.last = rx_in[i].last; rb.tid = psrc;
                rx_exp.push_back(rb);
                acc = '0; kp = '0; s = 0;
            end
        end
    endfunction

    task automatic tx_run(input int pct, input int budget);
        int bi, cyc;
        bit pv, pr;
        logic [FW-1:0] pd;
        logic pl;
        bi = 0; cyc = 0; pv = 0; pr = 0; pd = '0; pl = 0;
        tx_got.delete(); tx_gaps = 0; tx_nrdy = 0; tx_unstable = 0; tx_timeout = 0;
        while (!(bi == tx_in.size() && tx_got.size() >= tx_exp.size())) begin
            if (cyc == budget) begin tx_timeout = 1; break; end
            @(negedge clk);
            if (bi < tx_in.size()) begin
                s_axis_tvalid = 1; s_axis_tdata = tx_in[bi].data; s_axis_tkeep = tx_in[bi].keep;
                s_axis_tlast = tx_in[bi].last; s_axis_tdest = tx_in[bi].dest; s_axis_tid = tx_in[bi].src;
            end else s_axis_tvalid = 0;
            tx_flit_ready = ($urandom_range(99) < pct);
            #1;
            if (pv && !pr && (tx_flit_valid !== 1'b1 || tx_flit_data !== pd || tx_flit_last !== pl))
                tx_unstable++;
            pv = tx_flit_valid; pr = tx_flit_ready; pd = tx_flit_data; pl = tx_flit_last;
            if (!s_axis_tready) tx_nrdy++;
            if (tx_got.size() > 0 && tx_got.size() < tx_exp.size() && !tx_flit_valid) tx_gaps++;
            if (tx_flit_valid && tx_flit_ready) begin
                flit_t f;
                f.data = tx_flit_data; f.last = tx_flit_last; f.dest = tx_flit_dest; f.src = tx_flit_src;
                tx_got.push_back(f);
            end
            if (s_axis_tvalid && s_axis_tready) bi++;
            cyc++;
        end
        @(negedge clk);
        s_axis_tvalid = 0; tx_flit_ready = 0;
        foreach (tx_in[b]) if (tx_in[b].last) exp_tx_cnt++;
    endtask

    task automatic rx_run(input int pct, input int budget);
        int fi, cyc;
        fi = 0; cyc = 0; rx_timeout = 0;
        rx_got.delete();
        while (!(fi == rx_in.size() && rx_got.size() >= rx_exp.size())) begin
            if (cyc == budget) begin rx_timeout = 1; break; end
            @(negedge clk);
            if (fi < rx_in.size()) begin
                rx_flit_valid = 1; rx_flit_data = rx_in[fi].data;
                rx_flit_last = rx_in[fi].last; rx_flit_src = rx_in[fi].src;
            end else rx_flit_valid = 0;
            m_axis_tready = ($urandom_range(99) < pct);
            #1;
            if (m_axis_tvalid && m_axis_tready) begin
                rbeat_t rb;
                rb.data = m_axis_tdata; rb.keep = m_axis_tkeep; rb.last = m_axis_tlast; rb.tid = m_axis_tid;
                rx_got.push_back(rb);
            end
            if (rx_flit_valid && rx_flit_ready) fi++;
            cyc++;
        end
        @(negedge clk);
        rx_flit_valid = 0; m_axis_tready = 0;
        foreach (rx_in[i]) if (rx_in[i].last) exp_rx_cnt++;
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (3) @(negedge clk);
        reset = 0;
        @(negedge clk);
        n_cmp++; if (tx_flit_valid !== 1'b0) begin n_bad++; $display("FAIL reset_tx_valid got %b want 0", tx_flit_valid); end
        n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_bad++; $display("FAIL reset_m_valid got %b want 0", m_axis_tvalid); end
        n_cmp++; if (s_axis_tready !== 1'b1) begin n_bad++; $display("FAIL reset_s_ready got %b want 1", s_axis_tready); end
        n_cmp++; if (rx_flit_ready !== 1'b1) begin n_bad++; $display("FAIL reset_rx_ready got %b want 1", rx_flit_ready); end
        n_cmp++; if (tx_pkt_count !== '0 || rx_pkt_count !== '0) begin n_bad++;
            $display("FAIL reset_counts got %0d/%0d want 0/0", tx_pkt_count, rx_pkt_count); end
        n_cmp++; if (rx_src_error !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", rx_src_error); end
        n_cmp++; if (m_axis_tdest !== AW'(LA)) begin n_bad++; $display("FAIL tdest got %0d want %0d", m_axis_tdest, LA); end
    endtask

    task automatic test_tx_single();
        beat_t b;
        b.data = rnd_beat(); b.keep = 4'b1111; b.last = 1; b.dest = 4'd5; b.src = 4'd9;
        tx_in.delete(); tx_in.push_back(b);
        model_tx();
        tx_run(100, 100);
        n_cmp++; if (tx_timeout || tx_got.size() != 4) begin n_bad++;
            $display("FAIL single_count got %0d flits want 4 (timeout=%0d)", tx_got.size(), tx_timeout); end
        for (int i = 0; i < tx_got.size() && i < tx_exp.size(); i++) begin
            n_cmp++;
            if (tx_got[i] !== tx_exp[i]) begin n_bad++;
                $display("FAIL single_flit[%0d] got %h/%b/%0d/%0d want %h/%b/%0d/%0d", i, tx_got[i].data,
                    tx_got[i].last, tx_got[i].dest, tx_got[i].src, tx_exp[i].data, tx_exp[i].last,
                    tx_exp[i].dest, tx_exp[i].src); end
        end
        n_cmp++; if (tx_nrdy != 3) begin n_bad++; $display("FAIL single_tready_low got %0d cycles want 3", tx_nrdy); end
        n_cmp++; if (tx_pkt_count !== CW'(exp_tx_cnt)) begin n_bad++;
            $display("FAIL single_tx_count got %0d want %0d", tx_pkt_count, exp_tx_cnt); end
    endtask

    task automatic test_tx_keep_b2b();
        beat_t b;
        tx_in.delete();
        b.data = rnd_beat(); b.keep = 4'b0000; b.last = 0; b.dest = 4'd1; b.src = 4'd2; tx_in.push_back(b);
        b.data = rnd_beat(); b.keep = 4'b0011; b.last = 1; tx_in.push_back(b);
        b.data = rnd_beat(); b.keep = 4'b1111; b.last = 1; b.dest = 4'd3; b.src = 4'd4; tx_in.push_back(b);
        model_tx();
        tx_run(100, 100);
        n_cmp++; if (tx_timeout || tx_got.size() != 10) begin n_bad++;
            $display("FAIL b2b_count got %0d flits want 10 (timeout=%0d)", tx_got.size(), tx_timeout); end
        for (int i = 0; i < tx_got.size() && i < tx_exp.size(); i++) begin
            n_cmp++;
            if (tx_got[i] !== tx_exp[i]) begin n_bad++;
                $display("FAIL b2b_flit[%0d] got %h/%b want %h/%b", i, tx_got[i].data, tx_got[i].last,
                    tx_exp[i].data, tx_exp[i].last); end
        end
        n_cmp++; if (tx_gaps != 0) begin n_bad++; $display("FAIL b2b_bubbles got %0d want 0", tx_gaps); end
        n_cmp++; if (tx_pkt_count !== CW'(exp_tx_cnt)) begin n_bad++;
            $display("FAIL b2b_tx_count got %0d want %0d", tx_pkt_count, exp_tx_cnt); end
    endtask

    task automatic test_tx_random();
        beat_t b;
        int nb;
        tx_in.delete();
        for (int p = 0; p < 8; p++) begin
            nb = $urandom_range(3, 1);
            b.dest = AW'($urandom); b.src = AW'($urandom);
            for (int k = 0; k < nb; k++) begin
                b.data = rnd_beat(); b.keep = R'($urandom); b.last = (k == nb - 1);
                tx_in.push_back(b);
            end
        end
        model_tx();
        tx_run(50, 3000);
        n_cmp++; if (tx_timeout || tx_got.size() != tx_exp.size()) begin n_bad++;
            $display("FAIL rand_count got %0d flits want %0d (timeout=%0d)", tx_got.size(), tx_exp.size(), tx_timeout); end
        for (int i = 0; i < tx_got.size() && i < tx_exp.size(); i++) begin
            n_cmp++;
            if (tx_got[i] !== tx_exp[i]) begin n_bad++;
                $display("FAIL rand_flit[%0d] got %h/%b/%0d/%0d want %h/%b/%0d/%0d", i, tx_got[i].data,
                    tx_got[i].last, tx_got[i].dest, tx_got[i].src, tx_exp[i].data, tx_exp[i].last,
                    tx_exp[i].dest, tx_exp[i].src); end
        end
        n_cmp++; if (tx_unstable != 0) begin n_bad++; $display("FAIL rand_stall_stable got %0d changes want 0", tx_unstable); end
        n_cmp++; if (tx_pkt_count !== CW'(exp_tx_cnt)) begin n_bad++;
            $display("FAIL rand_tx_count got %0d want %0d", tx_pkt_count, exp_tx_cnt); end
    endtask

    task automatic test_rx_basic();
        rflit_t f;
        rx_in.delete();
        for (int i = 0; i < 5; i++) begin
            f.data = $urandom; f.last = (i == 4); f.src = 4'd3; rx_in.push_back(f);
        end
        model_rx();
        rx_run(100, 100);
        n_cmp++; if (rx_timeout || rx_got.size() != 2) begin n_bad++;
            $display("FAIL rxb_count got %0d beats want 2 (timeout=%0d)", rx_got.size(), rx_timeout); end
        for (int i = 0; i < rx_got.size() && i < rx_exp.size(); i++) begin
            n_cmp++;
            if (rx_got[i] !== rx_exp[i]) begin n_bad++;
                $display("FAIL rxb_beat[%0d] got %h/%b/%b/%0d want %h/%b/%b/%0d", i, rx_got[i].data, rx_got[i].keep,
                    rx_got[i].last, rx_got[i].tid, rx_exp[i].data, rx_exp[i].keep, rx_exp[i].last, rx_exp[i].tid); end
        end
        if (rx_got.size() == 2) begin
            n_cmp++; if (rx_got[1].keep !== 4'b0001 || rx_got[1].last !== 1'b1 || rx_got[1].tid !== 4'd3) begin n_bad++;
                $display("FAIL rxb_tail got keep=%b last=%b tid=%0d want 0001/1/3", rx_got[1].keep, rx_got[1].last, rx_got[1].tid); end
        end
        n_cmp++; if (rx_pkt_count !== CW'(exp_rx_cnt)) begin n_bad++;
            $display("FAIL rxb_rx_count got %0d want %0d", rx_pkt_count, exp_rx_cnt); end
    endtask

    task automatic test_rx_random();
        rflit_t f;
        int n;
        rx_in.delete();
        for (int p = 0; p < 10; p++) begin
            n = $urandom_range(9, 1);
            f.src = AW'($urandom);
            for (int i = 0; i < n; i++) begin
                f.data = $urandom; f.last = (i == n - 1); rx_in.push_back(f);
            end
        end
        model_rx();
        rx_run(60, 3000);
        n_cmp++; if (rx_timeout || rx_got.size() != rx_exp.size()) begin n_bad++;
            $display("FAIL rxr_count got %0d beats want %0d (timeout=%0d)", rx_got.size(), rx_exp.size(), rx_timeout); end
        for (int i = 0; i < rx_got.size() && i < rx_exp.size(); i++) begin
            n_cmp++;
            if (rx_got[i] !== rx_exp[i]) begin n_bad++;
                $display("FAIL rxr_beat[%0d] got %h/%b/%b/%0d want %h/%b/%b/%0d", i, rx_got[i].data, rx_got[i].keep,
                    rx_got[i].last, rx_got[i].tid, rx_exp[i].data, rx_exp[i].keep, rx_exp[i].last, rx_exp[i].tid); end
        end
        n_cmp++; if (rx_pkt_count !== CW'(exp_rx_cnt)) begin n_bad++;
            $display("FAIL rxr_rx_count got %0d want %0d", rx_pkt_count, exp_rx_cnt); end
        n_cmp++; if (rx_src_error !== 1'b0) begin n_bad++; $display("FAIL rxr_err got %b want 0", rx_src_error); end
    endtask

    task automatic test_rx_src_error();
        rflit_t f;
        rx_in.delete();
        f.data = $urandom; f.last = 0; f.src = 4'd3; rx_in.push_back(f);
        f.data = $urandom; f.last = 0; f.src = 4'd5; rx_in.push_back(f);
        f.data = $urandom; f.last = 1; f.src = 4'd5; rx_in.push_back(f);
        model_rx();
        rx_run(100, 100);
        n_cmp++; if (rx_got.size() != 1 || rx_got[0] !== rx_exp[0]) begin n_bad++;
            $display("FAIL srcerr_beat got %0d beats want 1 matching model (tid 3)", rx_got.size()); end
        n_cmp++; if (rx_src_error !== 1'b1) begin n_bad++; $display("FAIL srcerr_set got %b want 1", rx_src_error); end
        rx_in.delete();
        f.data = $urandom; f.last = 0; f.src = 4'd7; rx_in.push_back(f);
        f.data = $urandom; f.last = 1; f.src = 4'd7; rx_in.push_back(f);
        model_rx();
        rx_run(100, 100);
        n_cmp++; if (rx_src_error !== 1'b1) begin n_bad++; $display("FAIL srcerr_sticky got %b want 1", rx_src_error); end
        n_cmp++; if (rx_got.size() != 1 || rx_got[0] !== rx_exp[0]) begin n_bad++;
            $display("FAIL srcerr_clean_beat got %0d beats want 1 matching model (tid 7)", rx_got.size()); end
    endtask

    task automatic test_reset_mid();
        beat_t b;
        b.data = rnd_beat(); b.keep = 4'b1111; b.last = 1; b.dest = 4'd6; b.src = 4'd8;
        @(negedge clk);
        s_axis_tvalid = 1; s_axis_tdata = b.data; s_axis_tkeep = b.keep; s_axis_tlast = 1;
        s_axis_tdest = b.dest; s_axis_tid = b.src; tx_flit_ready = 1;
        @(negedge clk);
        s_axis_tvalid = 0;
        repeat (2) @(negedge clk);
        n_cmp++; if (tx_flit_valid !== 1'b1 || tx_flit_data !== b.data[2*FW +: FW]) begin n_bad++;
            $display("FAIL midrst_pre got valid=%b data=%h want 1/%h", tx_flit_valid, tx_flit_data, b.data[2*FW +: FW]); end
        reset = 1;
        @(negedge clk);
        n_cmp++; if (tx_flit_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid got %b want 0", tx_flit_valid); end
        n_cmp++; if (tx_pkt_count !== '0 || rx_pkt_count !== '0) begin n_bad++;
            $display("FAIL midrst_counts got %0d/%0d want 0/0", tx_pkt_count, rx_pkt_count); end
        n_cmp++; if (rx_src_error !== 1'b0) begin n_bad++; $display("FAIL midrst_err got %b want 0", rx_src_error); end
        reset = 0; tx_flit_ready = 0;
        exp_tx_cnt = 0; exp_rx_cnt = 0;
        b.data = rnd_beat();
        tx_in.delete(); tx_in.push_back(b);
        model_tx();
        tx_run(100, 100);
        n_cmp++; if (tx_timeout || tx_got.size() != 4) begin n_bad++;
            $display("FAIL midrst_next_count got %0d want 4", tx_got.size()); end
        for (int i = 0; i < tx_got.size() && i < tx_exp.size(); i++) begin
            n_cmp++;
            if (tx_got[i] !== tx_exp[i]) begin n_bad++;
                $display("FAIL midrst_flit[%0d] got %h/%b want %h/%b", i, tx_got[i].data, tx_got[i].last,
                    tx_exp[i].data, tx_exp[i].last); end
        end
        n_cmp++; if (tx_pkt_count !== CW'(1)) begin n_bad++; $display("FAIL midrst_tx_count got %0d want 1", tx_pkt_count); end
    endtask

    initial begin
        reset = 1;
        s_axis_tvalid = 0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 0;
        s_axis_tdest = '0; s_axis_tid = '0; tx_flit_ready = 0;
        rx_flit_valid = 0; rx_flit_data = '0; rx_flit_last = 0; rx_flit_src = '0; m_axis_tready = 0;
        test_reset();
        test_tx_single();
        test_tx_keep_b2b();
        test_tx_random();
        test_rx_basic();
        test_rx_random();
        test_rx_src_error();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
